// File: rtl/alu_loader_pkg.sv
// Shared types and defaults for the ALU operand loader.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional timeout is enabled by defining ALU_LOADER_TIMEOUT_EN.
package alu_loader_pkg;

  localparam int DATA_W             = 8;
  localparam int OP_SEL_W           = 3;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // Encodings are visible on the debug bus, so they are pinned explicitly.
  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  // True while an operation has been started but not yet fully loaded.
  function automatic logic is_partial(input state_t s);
    return (s == LOAD_B) || (s == LOAD_OP);
  endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// Synchronises the asynchronous load pin and emits a one-cycle pulse per rising edge.
// Latency: SYNC_STAGES cycles from pin edge to pulse (pulse is consumed on the following edge).
// Backpressure: none; the pulse is free-running, a consumer that is not listening drops it.
module strobe_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   history;

  // Metastability chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      history <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], din};
      history <= sync[SYNC_STAGES-1];
    end
  end

  // A held level produces exactly one pulse.
  assign pulse = sync[SYNC_STAGES-1] & ~history;

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles A, B and op from an 8-bit bus over three strobes, runs one EXEC cycle, captures result.
// Latency: SYNC_STAGES+1 cycles pin-to-accept; result/done registered one cycle after EXEC.
// Backpressure: none; ena=0 freezes state and drops strobes. Timeout via ALU_LOADER_TIMEOUT_EN.
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                load,
  input  logic                clr,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_cout,
  output logic [DATA_W-1:0]   op_a,
  output logic [DATA_W-1:0]   op_b,
  output logic [OP_SEL_W-1:0] op_sel,
  output logic                op_valid,
  output logic [DATA_W-1:0]   result,
  output logic                cout,
  output logic                done,
  output logic [2:0]          state
`ifdef ALU_LOADER_TIMEOUT_EN
  ,
  output logic                timeout_flag
`endif
);

  // Reject configurations that cannot work before anything is built.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("alu_operand_loader: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("alu_operand_loader: TIMEOUT_CYCLES must be at least 1");
  end

  state_t st;
  logic   ld_pulse;
  logic   tmo;

  strobe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (load),
    .pulse(ld_pulse)
  );

  assign state = st;

`ifdef ALU_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Fires on the cycle the idle count would reach TIMEOUT_CYCLES.
  assign tmo = is_partial(st) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle counter for a partially loaded operation; any strobe, abort or state change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (ena) begin
      if (!is_partial(st) || ld_pulse || clr || tmo) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Load sequencer: all outputs registered; clr beats a coincident strobe, EXEC always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= LOAD_A;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= '0;
      op_valid <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      done     <= 1'b0;
`ifdef ALU_LOADER_TIMEOUT_EN
      timeout_flag <= 1'b0;
`endif
    end else if (ena) begin
      op_valid <= 1'b0;
      case (st)
        LOAD_A: begin
          if (clr) begin
            st <= LOAD_A;
          end else if (ld_pulse) begin
            op_a <= data_in;
            st   <= LOAD_B;
`ifdef ALU_LOADER_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
          end
        end
        LOAD_B: begin
          if (clr) begin
            st <= LOAD_A;
          end else if (ld_pulse) begin
            op_b <= data_in;
            st   <= LOAD_OP;
          end else if (tmo) begin
            st <= LOAD_A;
`ifdef ALU_LOADER_TIMEOUT_EN
            timeout_flag <= 1'b1;
`endif
          end
        end
        LOAD_OP: begin
          if (clr) begin
            st <= LOAD_A;
          end else if (ld_pulse) begin
            op_sel   <= data_in[OP_SEL_W-1:0];
            op_valid <= 1'b1;
            st       <= EXEC;
          end else if (tmo) begin
            st <= LOAD_A;
`ifdef ALU_LOADER_TIMEOUT_EN
            timeout_flag <= 1'b1;
`endif
          end
        end
        EXEC: begin
          result <= alu_result;
          cout   <= alu_cout;
          done   <= 1'b1;
          st     <= HOLD;
        end
        HOLD: begin
          if (clr) begin
            done <= 1'b0;
            st   <= LOAD_A;
          end else if (ld_pulse) begin
            op_a <= data_in;
            done <= 1'b0;
            st   <= LOAD_B;
`ifdef ALU_LOADER_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
          end
        end
        default: begin
          done <= 1'b0;
          st   <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomised self-checking bench for alu_operand_loader with a transaction-level model.
// Latency: checks pin-to-accept of SYNC+1 cycles and one-cycle EXEC.
// Backpressure: exercises ena=0 strobe dropping, clr priority and async reset.
module tb_alu_operand_loader;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       load = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic [7:0] op_a, op_b, result;
    logic [2:0] op_sel, state;
    logic       op_valid, cout, done;

    int n_cmp = 0;
    int n_fail = 0;

    // Transaction-level model of the loader.
    logic [2:0] m_state;
    logic [7:0] m_a, m_b, m_res;
    logic [2:0] m_sel;
    logic       m_cout, m_done;

    alu_operand_loader #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .data_in(data_in), .load(load), .clr(clr),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_valid(op_valid),
        .result(result), .cout(cout), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Stand-in for alu_8bit: {cout, result}.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a[7], a[6:0], 1'b0};
            default: return {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    always_comb {alu_cout, alu_result} = alu_ref(op_a, op_b, op_sel);

    wire [32:0] obs_vec = {state, op_a, op_b, op_sel, op_valid, result, cout, done};

    function automatic logic [32:0] model_vec();
        return {m_state, m_a, m_b, m_sel, 1'b0, m_res, m_cout, m_done};
    endfunction

    task automatic model_reset();
        m_state = 3'd0; m_a = 8'h00; m_b = 8'h00; m_sel = 3'd0;
        m_res = 8'h00; m_cout = 1'b0; m_done = 1'b0;
    endtask

    // One accepted strobe: fills the next field; the third completes an operation.
    task automatic model_accept(input logic [7:0] d);
        case (m_state)
            3'd0: begin m_a = d; m_state = 3'd1; end
            3'd1: begin m_b = d; m_state = 3'd2; end
            3'd2: begin
                m_sel = d[2:0];
                {m_cout, m_res} = alu_ref(m_a, m_b, m_sel);
                m_done = 1'b1;
                m_state = 3'd4;
            end
            default: begin m_a = d; m_done = 1'b0; m_state = 3'd1; end
        endcase
    endtask

    task automatic model_clr();
        m_state = 3'd0;
        m_done = 1'b0;
    endtask

    // Raise load for 'hold' cycles, then idle long enough for accept and EXEC to finish.
    task automatic do_strobe(input logic [7:0] d, input int hold);
        @(negedge clk);
        data_in = d;
        load = 1'b1;
        repeat (hold) @(negedge clk);
        load = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs_vec, model_vec());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        do_strobe(8'h05, 1);
        model_accept(8'h05);
        do_strobe(8'h03, 1);
        model_accept(8'h03);
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL add_ab_loaded: got %h expected %h", obs_vec, model_vec());
        end
        @(negedge clk);
        data_in = 8'h00;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({state, op_valid} !== {3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL add_not_early: got state=%0d op_valid=%b expected state=2 op_valid=0", state, op_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({state, op_valid, op_sel} !== {3'd3, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL add_exec: got state=%0d op_valid=%b sel=%0d expected state=3 op_valid=1 sel=0",
                     state, op_valid, op_sel);
        end
        model_accept(8'h00);
        @(negedge clk);
        n_cmp++;
        if (obs_vec !== model_vec() || result !== 8'h08 || cout !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL add_result: got %h expected %h (result 08 cout 0 done 1)", obs_vec, model_vec());
        end
    endtask

    task automatic test_carry();
        model_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        do_strobe(8'hF0, 2); model_accept(8'hF0);
        do_strobe(8'h20, 1); model_accept(8'h20);
        do_strobe(8'h00, 1); model_accept(8'h00);
        n_cmp++;
        if (obs_vec !== model_vec() || result !== 8'h10 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_result: got %h expected %h (result 10 cout 1)", obs_vec, model_vec());
        end
        do_strobe(8'h11, 1); model_accept(8'h11);
        n_cmp++;
        if (obs_vec !== model_vec() || op_a !== 8'h11 || state !== 3'd1 || done !== 1'b0 || result !== 8'h10) begin
            n_fail++;
            $display("FAIL carry_back_to_back: got %h expected %h", obs_vec, model_vec());
        end
    endtask

    task automatic test_held_level();
        do_strobe(8'h22, 50);
        model_accept(8'h22);
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL held_level_one_accept: got %h expected %h", obs_vec, model_vec());
        end
    endtask

    task automatic test_ena_drop();
        @(negedge clk);
        ena = 1'b0;
        do_strobe(8'($urandom), 2);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL ena_low_frozen: got %h expected %h", obs_vec, model_vec());
        end
        ena = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL ena_pulse_dropped: got %h expected %h", obs_vec, model_vec());
        end
        data_in = 8'($urandom);
        do_strobe(data_in, 1);
        model_accept(data_in);
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL ena_resume_op: got %h expected %h", obs_vec, model_vec());
        end
    endtask

    task automatic test_random_ops();
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            for (int f = 0; f < 3; f++) begin
                d = 8'($urandom);
                do_strobe(d, $urandom_range(1, 4));
                model_accept(d);
                n_cmp++;
                if (obs_vec !== model_vec()) begin
                    n_fail++;
                    $display("FAIL random_op%0d_field%0d: got %h expected %h", i, f, obs_vec, model_vec());
                end
            end
        end
    endtask

    task automatic test_clr();
        // Finish the partial operation left by the random loop so the bench starts from HOLD.
        while (m_state != 3'd4) begin
            data_in = 8'($urandom);
            do_strobe(data_in, 1);
            model_accept(data_in);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clr();
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL clr_in_hold: got %h expected %h", obs_vec, model_vec());
        end
        do_strobe(8'hAA, 1); model_accept(8'hAA);
        do_strobe(8'h55, 1); model_accept(8'h55);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clr();
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL clr_partial: got %h expected %h", obs_vec, model_vec());
        end
        // Assert clr exactly on the cycle the strobe pulse is live.
        @(negedge clk);
        data_in = 8'h77;
        load = 1'b1;
        repeat (SYNC) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        load = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs_vec !== model_vec() || op_a !== 8'hAA) begin
            n_fail++;
            $display("FAIL clr_beats_strobe: got %h expected %h", obs_vec, model_vec());
        end
    endtask

    task automatic test_async_reset();
        logic saw_done;
        do_strobe(8'h3C, 1); model_accept(8'h3C);
        do_strobe(8'hC3, 1); model_accept(8'hC3);
        n_cmp++;
        if (state !== 3'd2) begin
            n_fail++;
            $display("FAIL areset_setup: got state=%0d expected 2", state);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h expected %h", obs_vec, model_vec());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0 || obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL areset_no_done: got saw_done=%b vec=%h expected saw_done=0 vec=%h",
                     saw_done, obs_vec, model_vec());
        end
    endtask

    task automatic test_no_timeout();
        do_strobe(8'h42, 1);
        model_accept(8'h42);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (obs_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL partial_waits: got %h expected %h", obs_vec, model_vec());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_add();
        test_carry();
        test_held_level();
        test_ena_drop();
        test_random_ops();
        test_clr();
        test_async_reset();
        test_no_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
